// File: rtl/fltfix_pkg.sv
// fltfix_pkg: shared types and constants for the float-to-fixed converter.
//   state_t      - converter FSM states
//   EXP_W/MANT_W - packed float field widths; BIAS - exponent bias
//   FIX_W        - width of the signed fixed-point result
//   SRC_ADDR/DST_ADDR - data-memory locations of operand and result
//   EXP_*        - exponent classification thresholds
//   SAT_POS/SAT_NEG - saturation results
package fltfix_pkg;

   localparam int unsigned EXP_W  = 5;
   localparam int unsigned MANT_W = 10;
   localparam int unsigned BIAS   = 15;
   localparam int unsigned FIX_W  = 16;

   localparam logic [7:0] SRC_ADDR = 8'd132;
   localparam logic [7:0] DST_ADDR = 8'd134;

   // Below 0.5 everything rounds to zero; at 2^10 the significand is already
   // integral; from 2^15 up the magnitude no longer fits the signed result.
   localparam logic [EXP_W-1:0] EXP_ZERO_MAX = 5'd13;
   localparam logic [EXP_W-1:0] EXP_LEFT_MIN = EXP_W'(BIAS + MANT_W);
   localparam logic [EXP_W-1:0] EXP_SAT_MIN  = 5'd30;

   localparam logic [FIX_W-1:0] SAT_POS = 16'h7FFF;
   localparam logic [FIX_W-1:0] SAT_NEG = 16'h8000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_HI,
      S_RD_LO,
      S_PREP,
      S_SHIFT,
      S_FIN,
      S_WR_HI,
      S_WR_LO
   } state_t;

endpackage

// File: rtl/fltfix_shift_round.sv
// fltfix_shift_round: 16-bit magnitude shifter with guard/sticky tracking and
// round-to-nearest-even increment.
//   clk, reset - clock, synchronous active-low reset
//   load       - load significand, clear guard/sticky
//   load_sig   - 11-bit significand {1, mantissa}
//   shl, shr   - shift magnitude one bit left (zero-fill) / right
//   round      - enable the RNE increment; mag_rnd reflects it combinationally
//   mag_rnd    - current magnitude plus rounding increment
module fltfix_shift_round
   import fltfix_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [MANT_W:0]   load_sig,
   input  logic              shl,
   input  logic              shr,
   input  logic              round,
   output logic [FIX_W-1:0]  mag_rnd
);

   logic [FIX_W-1:0] mag;
   logic             guard;
   logic             sticky;
   logic             round_up;

   assign round_up = round & guard & (sticky | mag[0]);
   assign mag_rnd  = mag + FIX_W'(round_up);

   always_ff @(posedge clk) begin
      if (!reset) begin
         mag    <= '0;
         guard  <= 1'b0;
         sticky <= 1'b0;
      end else if (load) begin
         mag    <= FIX_W'(load_sig);
         guard  <= 1'b0;
         sticky <= 1'b0;
      end else if (shr) begin
         sticky <= sticky | guard;
         guard  <= mag[0];
         mag    <= mag >> 1;
      end else if (shl) begin
         mag <= mag << 1;
      end else if (round) begin
         mag <= mag_rnd;
      end
   end

endmodule

// File: rtl/fltfix_conv.sv
// fltfix_conv: sequential packed-float to signed 16-bit fixed converter.
// Reads the float at SRC_ADDR/SRC_ADDR+1, converts with RNE and saturation,
// writes the result to DST_ADDR/DST_ADDR+1 (high byte first).
//   clk, reset - clock, synchronous active-low reset
//   start      - conversion request, sampled in IDLE only
//   done       - result committed; held until the next accepted start
//   mem_addr, mem_wr_en, mem_wdata - data-memory request side
//   mem_rdata  - combinational read data for mem_addr
module fltfix_conv
   import fltfix_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       done,
   output logic [7:0] mem_addr,
   output logic       mem_wr_en,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata
);

   state_t           state;
   logic [7:0]       hi_b;
   logic [7:0]       lo_b;
   logic [3:0]       cnt;
   logic             dir_left;
   logic             special;
   logic [FIX_W-1:0] spec_val;
   logic [FIX_W-1:0] result;
   logic [FIX_W-1:0] mag_rnd;
   logic [EXP_W-1:0] exp_f;
   logic             sign;

   assign sign  = hi_b[7];
   assign exp_f = hi_b[6:2];

   fltfix_shift_round u_shift (
      .clk      (clk),
      .reset    (reset),
      .load     (state == S_PREP),
      .load_sig ({1'b1, hi_b[1:0], lo_b}),
      .shl      ((state == S_SHIFT) &&  dir_left),
      .shr      ((state == S_SHIFT) && !dir_left),
      .round    (state == S_FIN),
      .mag_rnd  (mag_rnd)
   );

   // Memory request is a pure decode of the state so reads see data in-cycle.
   always_comb begin
      mem_addr  = '0;
      mem_wr_en = 1'b0;
      mem_wdata = '0;
      case (state)
         S_RD_HI: mem_addr = SRC_ADDR;
         S_RD_LO: mem_addr = SRC_ADDR + 8'd1;
         S_WR_HI: begin
            mem_addr  = DST_ADDR;
            mem_wr_en = 1'b1;
            mem_wdata = result[15:8];
         end
         S_WR_LO: begin
            mem_addr  = DST_ADDR + 8'd1;
            mem_wr_en = 1'b1;
            mem_wdata = result[7:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         done     <= 1'b0;
         hi_b     <= '0;
         lo_b     <= '0;
         cnt      <= '0;
         dir_left <= 1'b0;
         special  <= 1'b0;
         spec_val <= '0;
         result   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  done  <= 1'b0;
                  state <= S_RD_HI;
               end
            end
            S_RD_HI: begin
               hi_b  <= mem_rdata;
               state <= S_RD_LO;
            end
            S_RD_LO: begin
               lo_b  <= mem_rdata;
               state <= S_PREP;
            end
            S_PREP: begin
               if (exp_f <= EXP_ZERO_MAX) begin
                  special  <= 1'b1;
                  spec_val <= '0;
                  state    <= S_FIN;
               end else if (exp_f >= EXP_SAT_MIN) begin
                  special  <= 1'b1;
                  spec_val <= sign ? SAT_NEG : SAT_POS;
                  state    <= S_FIN;
               end else if (exp_f >= EXP_LEFT_MIN) begin
                  special  <= 1'b0;
                  dir_left <= 1'b1;
                  cnt      <= 4'(exp_f - EXP_LEFT_MIN);
                  state    <= (exp_f == EXP_LEFT_MIN) ? S_FIN : S_SHIFT;
               end else begin
                  special  <= 1'b0;
                  dir_left <= 1'b0;
                  cnt      <= 4'(EXP_LEFT_MIN - exp_f);
                  state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= S_FIN;
            end
            S_FIN: begin
               if (special)
                  result <= spec_val;
               else if (sign && (mag_rnd != '0))
                  result <= '0 - mag_rnd;
               else
                  result <= mag_rnd;
               state <= S_WR_HI;
            end
            S_WR_HI: state <= S_WR_LO;
            S_WR_LO: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fltfix_conv.sv
// tb_fltfix_conv: directed-vector self-checking bench for fltfix_conv.
module tb_fltfix_conv;

   logic       clk;
   logic       reset;
   logic       start;
   logic       done;
   logic [7:0] mem_addr;
   logic       mem_wr_en;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   logic [7:0] mem [256];
   int         wr_cnt;
   logic [7:0] first_wr_addr;

   int n_checks;
   int n_fail;

   fltfix_conv dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_wr_en) begin
         mem[mem_addr] <= mem_wdata;
         if (wr_cnt == 0) first_wr_addr <= mem_addr;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // mode 1 pulses start for one cycle while the converter is shifting.
   task automatic convert(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                          input logic [15:0] exp_res, input int exp_lat, input int mode);
      int lat;
      @(negedge clk);
      mem[132] = hi;
      mem[133] = lo;
      mem[134] = 8'hAA;
      mem[135] = 8'hAA;
      wr_cnt   = 0;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         start = (mode == 1 && lat == 5);
      end
      start = 1'b0;
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_res"}, {mem[134], mem[135]}, exp_res);
      check({tag, "_wrs"}, wr_cnt, 2);
      check({tag, "_wr1"}, first_wr_addr, 8'd134);
      if (mode == 1) begin
         repeat (10) @(posedge clk);
         #1 check({tag, "_nowr"}, wr_cnt, 2);
      end
   endtask

   initial begin
      int highs;
      int consec;
      int t1;
      int t2;
      logic prev;

      n_checks = 0;
      n_fail   = 0;
      wr_cnt   = 0;
      first_wr_addr = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", done, 1'b0);
      check("rst_wren", mem_wr_en, 1'b0);
      check("rst_addr", mem_addr, 8'd0);
      check("rst_wdata", mem_wdata, 8'd0);
      @(negedge clk) reset = 1'b1;

      convert("one",     8'h3C, 8'h00, 16'h0001, 16, 0);
      convert("tie2p5",  8'h41, 8'h00, 16'h0002, 15, 0);
      convert("tie3p5",  8'h43, 8'h00, 16'h0004, 15, 0);
      convert("half",    8'h38, 8'h00, 16'h0000, 17, 0);
      convert("neg1000", 8'hE3, 8'hD0, 16'hFC18, 7,  0);
      convert("lshift",  8'h77, 8'hFF, 16'h7FF0, 10, 0);
      convert("sat_pos", 8'h78, 8'h00, 16'h7FFF, 6,  0);
      convert("sat_neg", 8'hF8, 8'h00, 16'h8000, 6,  0);
      convert("inf",     8'h7C, 8'h00, 16'h7FFF, 6,  0);
      convert("negzero", 8'h80, 8'h00, 16'h0000, 6,  0);
      convert("subnorm", 8'h03, 8'h55, 16'h0000, 6,  0);
      convert("e25",     8'h64, 8'h01, 16'h0401, 6,  0);
      convert("startig", 8'h3C, 8'h00, 16'h0001, 16, 1);

      // Reset in the middle of a shift: back to idle, nothing written.
      @(negedge clk);
      mem[132] = 8'h3C;
      mem[133] = 8'h00;
      mem[134] = 8'hAA;
      mem[135] = 8'hAA;
      wr_cnt   = 0;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      check("mrst_done", done, 1'b0);
      check("mrst_addr", mem_addr, 8'd0);
      reset = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("mrst_wrs", wr_cnt, 0);
      check("mrst_dst", {mem[134], mem[135]}, 16'hAAAA);
      convert("postrst", 8'h41, 8'h00, 16'h0002, 15, 0);

      // Start held high: done pulses once per conversion, 17 cycles apart.
      @(negedge clk);
      mem[132] = 8'h3C;
      mem[133] = 8'h00;
      start  = 1'b1;
      highs  = 0;
      consec = 0;
      t1     = 0;
      t2     = 0;
      prev   = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            highs++;
            if (prev) consec++;
            if (t1 == 0) t1 = c;
            else if (t2 == 0) t2 = c;
         end
         prev = done;
      end
      start = 1'b0;
      repeat (30) @(posedge clk);
      check("hold_highs", highs, 3);
      check("hold_first", t1, 17);
      check("hold_period", t2 - t1, 17);
      check("hold_consec", consec, 0);
      check("hold_res", {mem[134], mem[135]}, 16'h0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
